dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory / memory-mapped I/O bus (RAM window plus port registers) between the CPU load/store path (M0) and a secondary master (M1: DMA or debug loader).
- Registered grant FSM with round-robin fairness, optional bus lock for multi-word sequences, and a hold limit to bound starvation.
- Sits between the requesters and the memory/IO block; downstream is single-cycle: combinational read, write on the rising edge of `clk`.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, max consecutive grants to one locked master before forced release (≥2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 transaction request.
- m0_we  in  1  M0 write enable.
- m0_lock  in  1  M0 requests to keep the grant after this beat.
- m0_addr  in  AW  M0 byte address.
- m0_wd  in  DW  M0 write data.
- m0_ack  out  1  M0 beat completed this cycle.
- m0_rd  out  DW  M0 read data, valid when m0_ack=1.
- m1_req, m1_we, m1_lock, m1_addr, m1_wd, m1_ack, m1_rd: same as M0, for M1.
- mem_we  out  1  downstream write enable.
- mem_a  out  AW  downstream address.
- mem_wd  out  DW  downstream write data.
- mem_rd  in  DW  downstream read data (combinational from mem_a).
- owner  out  2  current grant: 00 none, 01 M0, 10 M1.

Behaviour:
- FSM states: IDLE, GNT0, GNT1. State register holds the grant; the bus mux is driven from state only, never combinationally from req.
- Handshake:
  - Master raises req with we/addr/wd stable; holds them until ack.
  - In GNTx, mem_a=mx_addr, mem_wd=mx_wd, mem_we=mx_we&mx_req, mx_ack=mx_req, mx_rd=mem_rd.
  - A beat completes in one cycle.
  - Non-granted master: ack=0, rd=0.
- Latency: req seen in IDLE at cycle N → ack at N+1. Back-to-back beats from the same master cost 1 cycle each while it keeps the grant.
- Next-state rules, evaluated every cycle:
  - IDLE: one request → grant it. Both requesting → grant the master ≠ last_grant (M0 after reset).
  - GNTx, mx_lock=1, mx_req=1, hold_cnt<MAX_HOLD-1 → stay; hold_cnt++.
  - GNTx otherwise: other master requesting → switch, hold_cnt=0. Only mx requesting → stay, hold_cnt=0. No requests → IDLE.
  - last_grant is updated on every entry to GNT0/GNT1.
- Forced release: when hold_cnt reaches MAX_HOLD-1 and the other master is requesting, switch regardless of lock. With no competitor, stay and wrap hold_cnt to 0.
- Request drop mid-grant (req=0 in GNTx): no ack, no mem_we; transition as above.
- Idle bus: mem_we=0, mem_a=0, mem_wd=0, owner=00.
- Reset (async assert, any state): state=IDLE, last_grant=M1 (so M0 wins first tie), hold_cnt=0; all outputs 0 immediately. An in-flight beat is abandoned with no write.
- mem_we is never asserted for a non-owner under any input combination.

Optional Feature:
- ARB_STATS_EN:
  - Defined: adds 16-bit saturating counters grant_cnt0, grant_cnt1 (count acked beats) and wait_cnt (cycles where a req is pending without ack), exposed as output ports; a clr_stats input zeroes them synchronously; reset zeroes them.
  - Undefined: the ports, counters and clr_stats are absent; core behaviour is identical.

Decomposition:
- Shared package `dmem_arb_pkg`: state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10; matches owner), owner codes, MAX_HOLD default, bus-address constants used by requesters (RAM window 0x1000–0x17FF, port addresses 0x7F00/0x7F10/0x7F20/0x7FFC).
- Sub-module `rr_pick2`: combinational 2-way round-robin chooser (req[1:0], last_grant → pick). Everything else stays in the top module.

Test Plan:
- Reset then m0_req=1 write addr 0x1004 wd 0xDEADBEEF at cycle 1 → cycle 2: owner=01, m0_ack=1, mem_we=1, mem_a=0x1004. M0 read of the same address next → m0_rd=0xDEADBEEF.
- Both req assert together from IDLE repeatedly (no lock) → grants alternate M0, M1, M0, M1. Each ack one cycle. Never both acks in one cycle.
- M0 lock=1 continuous, M1 req=1, MAX_HOLD=8 → M0 gets exactly 8 consecutive acks, then M1 is granted for ≥1 beat.
- M1 lock=1 alone for 20 cycles → continuous ack, hold_cnt wraps, no drop to IDLE.
- Assert reset_n=0 mid GNT1 write (async, between edges) → owner=00, mem_we=0 immediately. The memory location is unchanged after release.
- With ARB_STATS_EN: 5 M0 beats + 3 M1 beats with contention → grant_cnt0=5, grant_cnt1=3, wait_cnt equals the measured stall cycles. clr_stats → all 0 next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arb_pkg : shared encodings and bus map for the dmem bus arbiter     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dmem_arb_pkg;

  // State encoding doubles as the owner code driven on the owner port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] c_own_none = 2'b00;
  localparam logic [1:0] c_own_m0   = 2'b01;
  localparam logic [1:0] c_own_m1   = 2'b10;

  localparam int c_max_hold_def = 8;

  localparam logic [31:0] c_ram_base = 32'h0000_1000;
  localparam logic [31:0] c_ram_last = 32'h0000_17FF;
  localparam logic [31:0] c_port_a   = 32'h0000_7F00;
  localparam logic [31:0] c_port_b   = 32'h0000_7F10;
  localparam logic [31:0] c_port_c   = 32'h0000_7F20;
  localparam logic [31:0] c_port_d   = 32'h0000_7FFC;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick2 : combinational 2-way round-robin chooser                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  logic        last_grant,
  output arb_state_t  pick
);

  // last_grant: 0 = M0 was granted last, 1 = M1 was granted last.
  always_comb begin
    pick = ST_IDLE;
    case (req)
      2'b01:   pick = ST_GNT0;
      2'b10:   pick = ST_GNT1;
      2'b11:   pick = last_grant ? ST_GNT0 : ST_GNT1;
      default: pick = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_bus_arbiter : two-master round-robin arbiter for the dmem/IO bus,   |
// | with lock and hold limit. Optional stats counters under ARB_STATS_EN.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = c_max_hold_def
) (
`ifdef ARB_STATS_EN
  input  logic          clr_stats,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1,
  output logic [15:0]   wait_cnt,
`endif
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    owner
);

  localparam int                    c_hold_w    = $clog2(MAX_HOLD);
  localparam logic [c_hold_w-1:0]   c_hold_last = c_hold_w'(MAX_HOLD - 1);

  arb_state_t           r_state;
  logic                 r_last_grant;
  logic [c_hold_w-1:0]  r_hold_cnt;

  arb_state_t           w_pick;
  arb_state_t           w_next_state;
  logic [c_hold_w-1:0]  w_next_hold;
  logic                 w_cur_req;
  logic                 w_cur_lock;

  rr_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (r_last_grant),
    .pick       (w_pick)
  );

  // While granted, last_grant equals the owner, so the chooser also yields the
  // release decision: switch on contention, stay if alone, else go idle.
  always_comb begin
    w_cur_req    = (r_state == ST_GNT0) ? m0_req  : m1_req;
    w_cur_lock   = (r_state == ST_GNT0) ? m0_lock : m1_lock;
    w_next_state = w_pick;
    w_next_hold  = '0;
    if ((r_state != ST_IDLE) && w_cur_lock && w_cur_req && (r_hold_cnt != c_hold_last)) begin
      w_next_state = r_state;
      w_next_hold  = r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_hold_cnt   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= w_next_hold;
      if (w_next_state == ST_GNT0)
        r_last_grant <= 1'b0;
      else if (w_next_state == ST_GNT1)
        r_last_grant <= 1'b1;
    end
  end

  // Bus mux is a function of the registered grant only.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    m0_ack = 1'b0;
    m0_rd  = '0;
    m1_ack = 1'b0;
    m1_rd  = '0;
    case (r_state)
      ST_GNT0: begin
        mem_a  = m0_addr;
        mem_wd = m0_wd;
        mem_we = m0_we & m0_req;
        m0_ack = m0_req;
        m0_rd  = mem_rd;
      end
      ST_GNT1: begin
        mem_a  = m1_addr;
        mem_wd = m1_wd;
        mem_we = m1_we & m1_req;
        m1_ack = m1_req;
        m1_rd  = mem_rd;
      end
      default: ;
    endcase
  end

  assign owner = r_state;

`ifdef ARB_STATS_EN
  logic w_waiting;
  assign w_waiting = (m0_req & ~m0_ack) | (m1_req & ~m1_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt   <= '0;
    end else if (clr_stats) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt   <= '0;
    end else begin
      if (m0_ack && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (m1_ack && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (w_waiting && !(&wait_cnt)) wait_cnt <= wait_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_bus_arbiter : directed self-checking bench for dmem_bus_arbiter  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_ack, m1_ack, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_a, mem_wd, mem_rd;
  logic [1:0]  owner;
`ifdef ARB_STATS_EN
  logic        clr_stats;
  logic [15:0] grant_cnt0, grant_cnt1, wait_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] tb_mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_we) tb_mem[mem_a[11:2]] <= mem_wd;
  assign mem_rd = tb_mem[mem_a[11:2]];

  dmem_bus_arbiter dut (
`ifdef ARB_STATS_EN
    .clr_stats  (clr_stats),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .wait_cnt   (wait_cnt),
`endif
    .clk     (clk),
    .reset_n (reset_n),
    .m0_req  (m0_req),
    .m0_we   (m0_we),
    .m0_lock (m0_lock),
    .m0_addr (m0_addr),
    .m0_wd   (m0_wd),
    .m0_ack  (m0_ack),
    .m0_rd   (m0_rd),
    .m1_req  (m1_req),
    .m1_we   (m1_we),
    .m1_lock (m1_lock),
    .m1_addr (m1_addr),
    .m1_wd   (m1_wd),
    .m1_ack  (m1_ack),
    .m1_rd   (m1_rd),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd),
    .owner   (owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read at +3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wd = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ARB_STATS_EN
    clr_stats = 1'b0;
`endif
    do_reset();
    #1;
    check("rst_owner", {30'd0, owner}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);

    // Single write then read-back by M0.
    m0_req = 1; m0_we = 1; m0_addr = 32'h1004; m0_wd = 32'hDEADBEEF;
    #1;
    check("idle_no_ack", {31'd0, m0_ack}, 32'd0);
    tick(); #1;
    check("w_owner", {30'd0, owner}, 32'd1);
    check("w_ack", {31'd0, m0_ack}, 32'd1);
    check("w_mem_we", {31'd0, mem_we}, 32'd1);
    check("w_mem_a", mem_a, 32'h1004);
    check("w_mem_wd", mem_wd, 32'hDEADBEEF);
    check("w_m1_rd", m1_rd, 32'd0);
    tick();
    m0_we = 0;
    #1;
    check("r_ack", {31'd0, m0_ack}, 32'd1);
    check("r_data", m0_rd, 32'hDEADBEEF);
    check("r_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    m0_req = 0; m0_we = 1;
    #1;
    check("drop_owner", {30'd0, owner}, 32'd1);
    check("drop_ack", {31'd0, m0_ack}, 32'd0);
    check("drop_mem_we", {31'd0, mem_we}, 32'd0);
    tick(); #1;
    check("back_idle", {30'd0, owner}, 32'd0);
    check("idle_mem_a", mem_a, 32'd0);
    check("idle_mem_wd", mem_wd, 32'd0);

    // Simultaneous requests alternate starting with M0.
    do_reset();
    m0_req = 1; m0_addr = 32'h1004;
    m1_req = 1; m1_addr = 32'h1008;
    #1;
    check("alt_idle", {30'd0, owner}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check($sformatf("alt_owner%0d", i), {30'd0, owner}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("alt_ack0_%0d", i), {31'd0, m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("alt_ack1_%0d", i), {31'd0, m1_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    m0_req = 0; m1_req = 0;
    tick(); #1;
    check("alt_end_idle", {30'd0, owner}, 32'd0);

    // Locked M0 against competing M1: exactly 8 beats before release.
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h1010;
    m1_req = 1; m1_addr = 32'h1014;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("lock_ack0_%0d", i), {31'd0, m0_ack}, 32'd1);
      check($sformatf("lock_ack1_%0d", i), {31'd0, m1_ack}, 32'd0);
      tick();
    end
    #1;
    check("forced_owner", {30'd0, owner}, 32'd2);
    check("forced_ack1", {31'd0, m1_ack}, 32'd1);
    check("forced_ack0", {31'd0, m0_ack}, 32'd0);
    tick(); #1;
    check("return_owner", {30'd0, owner}, 32'd1);
    clear_inputs();
    tick();

    // Locked M1 alone keeps the bus indefinitely.
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h1020;
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("solo_owner%0d", i), {30'd0, owner}, 32'd2);
      check($sformatf("solo_ack%0d", i), {31'd0, m1_ack}, 32'd1);
      tick();
    end
    clear_inputs();
    tick();

    // Asynchronous reset in the middle of an M1 write beat.
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h1100; m1_wd = 32'hA5A5A5A5;
    tick();
    tick();
    m1_wd = 32'h5A5A5A5A;
    #1;
    check("pre_rst_we", {31'd0, mem_we}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_owner", {30'd0, owner}, 32'd0);
    check("async_mem_we", {31'd0, mem_we}, 32'd0);
    check("async_ack1", {31'd0, m1_ack}, 32'd0);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    m0_req = 1; m0_addr = 32'h1100;
    tick(); #1;
    check("rst_write_abandoned", m0_rd, 32'hA5A5A5A5);
    clear_inputs();
    tick();

`ifdef ARB_STATS_EN
    begin
      int rem0, rem1, stall;
      do_reset();
      rem0 = 5; rem1 = 3; stall = 0;
      m0_addr = 32'h1200; m1_addr = 32'h1204;
      for (int i = 0; i < 40; i++) begin
        if (rem0 == 0 && rem1 == 0) break;
        m0_req = (rem0 != 0);
        m1_req = (rem1 != 0);
        #1;
        if ((m0_req && !m0_ack) || (m1_req && !m1_ack)) stall++;
        if (m0_ack) rem0--;
        if (m1_ack) rem1--;
        tick();
      end
      clear_inputs();
      #1;
      check("stat_g0", {16'd0, grant_cnt0}, 32'd5);
      check("stat_g1", {16'd0, grant_cnt1}, 32'd3);
      check("stat_wait", {16'd0, wait_cnt}, stall);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      #1;
      check("clr_g0", {16'd0, grant_cnt0}, 32'd0);
      check("clr_g1", {16'd0, grant_cnt1}, 32'd0);
      check("clr_wait", {16'd0, wait_cnt}, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
